// File: rtl/gpc3_2.sv
// 3:2 generalized parallel counter (full-adder compressor) with an optional
// LATENCY-deep output pipeline and optional valid tracking.
module gpc3_2 #(
  parameter int LATENCY  = 0,
  parameter bit VALID_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] src0,
  input  logic       in_valid,
  output logic [1:0] dst,
  output logic       out_valid
);

  logic [1:0] count;

  always_comb begin
    count[0] = ^src0;
    count[1] = (src0[0] & src0[1]) | (src0[0] & src0[2]) | (src0[1] & src0[2]);
  end

  generate
    if (LATENCY < 0) begin : g_bad_latency
      $error("gpc3_2: LATENCY must be >= 0");
    end else if (LATENCY == 0) begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst};
      assign dst = count;

      if (VALID_EN) begin : g_valid
        assign out_valid = in_valid;
      end else begin : g_no_valid
        logic unused_in_valid;
        assign unused_in_valid = &{1'b0, in_valid};
        assign out_valid       = 1'b1;
      end
    end else begin : g_pipe
      logic [LATENCY-1:0][1:0] dst_q;
      logic [LATENCY-1:0][1:0] dst_d;

      // NOTE: every stage is assigned on every pass, so no latch is inferred.
      always_comb begin
        dst_d[0] = count;
        for (int i = 1; i < LATENCY; i++) begin
          dst_d[i] = dst_q[i-1];
        end
      end

      // NOTE: non-blocking assignments let all stages shift in lockstep on one edge.
      // NOTE: these are individual flops, not a RAM, so clearing them on reset is cheap and required.
      always_ff @(posedge clk) begin
        if (rst) begin
          dst_q <= '0;
        end else begin
          dst_q <= dst_d;
        end
      end

      assign dst = dst_q[LATENCY-1];

      if (VALID_EN) begin : g_valid
        logic [LATENCY-1:0] vld_q;
        logic [LATENCY-1:0] vld_d;

        always_comb begin
          vld_d[0] = in_valid;
          for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
          end
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            vld_q <= '0;
          end else begin
            vld_q <= vld_d;
          end
        end

        assign out_valid = vld_q[LATENCY-1];
      end else begin : g_no_valid
        logic unused_in_valid;
        assign unused_in_valid = &{1'b0, in_valid};
        assign out_valid       = 1'b1;
      end
    end
  endgenerate

endmodule

// File: tb/tb_gpc3_2.sv
// Self-checking bench for gpc3_2: directed literal checks plus a randomized run
// compared every cycle against a history-based model for latencies 0..3.
module tb_gpc3_2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] src0 = '0;
  logic       in_valid = 1'b0;

  logic [1:0] dst_l0, dst_l1, dst_l2, dst_l3, dst_nv;
  logic       ov_l0, ov_l1, ov_l2, ov_l3, ov_nv;

  int  n_cmp  = 0;
  int  n_fail = 0;
  bit  chk_en = 1'b0;

  // Inputs as sampled at every rising edge, oldest first.
  logic [2:0] h_src[$];
  logic       h_vld[$];
  logic       h_rst[$];

  always #5 clk = ~clk;

  gpc3_2 #(.LATENCY(0), .VALID_EN(1'b1)) u_l0 (
    .clk(clk), .rst(rst), .src0(src0), .in_valid(in_valid), .dst(dst_l0), .out_valid(ov_l0));
  gpc3_2 #(.LATENCY(1), .VALID_EN(1'b1)) u_l1 (
    .clk(clk), .rst(rst), .src0(src0), .in_valid(in_valid), .dst(dst_l1), .out_valid(ov_l1));
  gpc3_2 #(.LATENCY(2), .VALID_EN(1'b1)) u_l2 (
    .clk(clk), .rst(rst), .src0(src0), .in_valid(in_valid), .dst(dst_l2), .out_valid(ov_l2));
  gpc3_2 #(.LATENCY(3), .VALID_EN(1'b1)) u_l3 (
    .clk(clk), .rst(rst), .src0(src0), .in_valid(in_valid), .dst(dst_l3), .out_valid(ov_l3));
  gpc3_2 #(.LATENCY(1), .VALID_EN(1'b0)) u_nv (
    .clk(clk), .rst(rst), .src0(src0), .in_valid(in_valid), .dst(dst_nv), .out_valid(ov_nv));

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output of an N-stage pipe after the latest edge: the sample taken N-1 edges
  // before it, unless any reset edge fell inside that window.
  function automatic void model(input int n, output logic [1:0] d, output logic v);
    int  k;
    int  idx;
    bit  clr;
    k   = h_src.size() - 1;
    idx = k - n + 1;
    clr = 1'b0;
    for (int j = idx; j <= k; j++) begin
      if (h_rst[j]) clr = 1'b1;
    end
    if (clr) begin
      d = 2'd0;
      v = 1'b0;
    end else begin
      d = 2'($countones(h_src[idx]));
      v = h_vld[idx];
    end
  endfunction

  always @(posedge clk) begin
    h_src.push_back(src0);
    h_vld.push_back(in_valid);
    h_rst.push_back(rst);
  end

  // Per-cycle compare process against the model.
  initial begin
    logic [1:0] d;
    logic       v;
    forever begin
      @(negedge clk);
      if (chk_en && h_src.size() >= 3) begin
        check("l0_dst", {2'b0, dst_l0}, {2'b0, 2'($countones(src0))});
        check("l0_valid", {3'b0, ov_l0}, {3'b0, in_valid});
        model(1, d, v);
        check("l1_dst", {2'b0, dst_l1}, {2'b0, d});
        check("l1_valid", {3'b0, ov_l1}, {3'b0, v});
        check("nv_dst", {2'b0, dst_nv}, {2'b0, d});
        check("nv_valid", {3'b0, ov_nv}, 4'd1);
        model(2, d, v);
        check("l2_dst", {2'b0, dst_l2}, {2'b0, d});
        check("l2_valid", {3'b0, ov_l2}, {3'b0, v});
        model(3, d, v);
        check("l3_dst", {2'b0, dst_l3}, {2'b0, d});
        check("l3_valid", {3'b0, ov_l3}, {3'b0, v});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Drive new inputs 1 unit after a rising edge; they are sampled on the next edge.
  task automatic tick(input logic [2:0] s, input logic v, input logic r);
    @(posedge clk);
    #1;
    src0     = s;
    in_valid = v;
    rst      = r;
  endtask

  initial begin
    int exp_tab[8];
    int seq_in[10];
    int seq_exp[10];
    logic [2:0] s;
    exp_tab = '{0, 1, 1, 2, 1, 2, 2, 3};
    seq_in  = '{1, 7, 0, 2, 6, 0, 4, 6, 3, 5};
    seq_exp = '{1, 3, 0, 1, 2, 0, 1, 2, 2, 2};

    // Reset state.
    tick(3'd7, 1'b1, 1'b1);
    tick(3'd7, 1'b1, 1'b1);
    tick(3'd0, 1'b0, 1'b1);
    check("reset_l2_dst", {2'b0, dst_l2}, 4'd0);
    check("reset_l2_valid", {3'b0, ov_l2}, 4'd0);
    check("reset_l3_dst", {2'b0, dst_l3}, 4'd0);
    check("reset_l1_valid", {3'b0, ov_l1}, 4'd0);
    chk_en = 1'b1;
    tick(3'd0, 1'b0, 1'b0);

    // Combinational path: changes land on odd times, never on a falling edge.
    for (int i = 0; i < 8; i++) begin
      #1 src0 = 3'(i);
      #1 check("l0_exhaustive", {2'b0, dst_l0}, 4'(exp_tab[i]));
    end
    for (int i = 0; i < 10; i++) begin
      #1 src0 = 3'(seq_in[i]);
      #1 check("l0_sequence", {2'b0, dst_l0}, 4'(seq_exp[i]));
    end

    // LATENCY=2 burst 7,5,4,0 with valid.
    tick(3'd0, 1'b0, 1'b0);
    tick(3'd0, 1'b0, 1'b0);
    tick(3'd7, 1'b1, 1'b0);
    check("l2_burst_pre_valid", {3'b0, ov_l2}, 4'd0);
    tick(3'd5, 1'b1, 1'b0);
    check("l2_burst_pre_valid2", {3'b0, ov_l2}, 4'd0);
    tick(3'd4, 1'b1, 1'b0);
    check("l2_burst_dst7", {2'b0, dst_l2}, 4'd3);
    check("l2_burst_valid7", {3'b0, ov_l2}, 4'd1);
    tick(3'd0, 1'b1, 1'b0);
    check("l2_burst_dst5", {2'b0, dst_l2}, 4'd2);
    tick(3'd0, 1'b0, 1'b0);
    check("l2_burst_dst4", {2'b0, dst_l2}, 4'd1);
    check("l2_burst_valid4", {3'b0, ov_l2}, 4'd1);
    tick(3'd0, 1'b0, 1'b0);
    check("l2_burst_dst0", {2'b0, dst_l2}, 4'd0);
    check("l2_burst_valid0", {3'b0, ov_l2}, 4'd1);
    tick(3'd0, 1'b0, 1'b0);
    check("l2_burst_post_valid", {3'b0, ov_l2}, 4'd0);

    // LATENCY=2 reset while 7 is in flight, then 3 after release.
    tick(3'd7, 1'b1, 1'b0);
    tick(3'd0, 1'b0, 1'b1);
    tick(3'd3, 1'b1, 1'b0);
    check("l2_rst_dst", {2'b0, dst_l2}, 4'd0);
    check("l2_rst_valid", {3'b0, ov_l2}, 4'd0);
    tick(3'd0, 1'b0, 1'b0);
    tick(3'd0, 1'b0, 1'b0);
    check("l2_after_rst_dst", {2'b0, dst_l2}, 4'd2);
    check("l2_after_rst_valid", {3'b0, ov_l2}, 4'd1);

    // LATENCY=1 valid toggling 1,0,1.
    tick(3'd6, 1'b1, 1'b0);
    tick(3'd1, 1'b0, 1'b0);
    check("l1_tog_dst6", {2'b0, dst_l1}, 4'd2);
    check("l1_tog_valid1", {3'b0, ov_l1}, 4'd1);
    tick(3'd5, 1'b1, 1'b0);
    check("l1_tog_dst1", {2'b0, dst_l1}, 4'd1);
    check("l1_tog_valid0", {3'b0, ov_l1}, 4'd0);
    tick(3'd0, 1'b0, 1'b0);
    check("l1_tog_dst5", {2'b0, dst_l1}, 4'd2);
    check("l1_tog_valid1b", {3'b0, ov_l1}, 4'd1);

    // Randomized run, checked every cycle by the compare process.
    for (int i = 0; i < 1000; i++) begin
      s = 3'($urandom_range(0, 7));
      tick(s, 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
    end
    tick(3'd0, 1'b0, 1'b0);
    tick(3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
